ctrl_sequencer: RTL and testbench

- Parametrised multi-cycle control sequencer for the 16-bit accumulator/register CPU.
- Successor to the single-cycle EX1 control decode. Owns the FETCH/DECODE/EX1/EX2 state machine, latches the instruction internally, stalls on memory handshakes, and emits decoded control fields instead of one opaque control word.
- Sits between instruction memory/data memory and the datapath (register file, ALU, PC).

---
 rtl/ctrl_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EX1/EX2 control sequencer for the 16-bit accumulator/register CPU.
// Optional WAIT_TIMEOUT_EN adds a bounded memory-wait counter and a bus_error pulse.
module ctrl_sequencer #(
   parameter int IR_W     = 16,
   parameter int REG_W    = 3,
   parameter int IMM_W    = 8,
   parameter int OPC_LSB  = 11,
   parameter int RD_LSB   = 8,
   parameter int RA_LSB   = 3,
   parameter int RB_LSB   = 6,
   parameter int MODE_BIT = 9,
   parameter int N_BIT    = 1,
   parameter int Z_BIT    = 0,
   parameter int TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IR_W-1:0]  ir_in,
   input  logic [3:0]       status,
   input  logic             mem_ready,
   output logic             ir_load,
   output logic [1:0]       pc_sel,
   output logic             addr_sel,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             rf_we,
   output logic [REG_W-1:0] rf_wsel,
   output logic [REG_W-1:0] rf_asel,
   output logic [REG_W-1:0] rf_bsel,
   output logic             md_sel,
   output logic [IR_W-1:0]  const_out,
   output logic [2:0]       state_out,
   output logic             instr_done,
   output logic             illegal,
   output logic             halted
`ifdef WAIT_TIMEOUT_EN
   ,
   output logic             bus_error
`endif
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EX1    = 3'd2;
   localparam logic [2:0] EX2    = 3'd3;
   localparam logic [2:0] HALT   = 3'd4;

   logic [2:0]       state;
   logic [2:0]       next_state;
   logic [IR_W-1:0]  ir;
   logic [2:0]       opc;
   logic             mode;
   logic             flag;
   logic [REG_W-1:0] rd_f;
   logic [REG_W-1:0] ra_f;
   logic [REG_W-1:0] rb_f;
   logic [IR_W-1:0]  imm_ext;
   logic             unused_bits;

   assign opc     = ir[OPC_LSB +: 3];
   assign mode    = ir[MODE_BIT];
   assign rd_f    = ir[RD_LSB +: REG_W];
   assign ra_f    = ir[RA_LSB +: REG_W];
   assign rb_f    = ir[RB_LSB +: REG_W];
   assign imm_ext = IR_W'(ir[IMM_W-1:0]);
   assign flag    = opc[0] ? status[N_BIT] : status[Z_BIT];

   assign unused_bits = ^{status, ir, 32'(TIMEOUT)};

`ifdef WAIT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] stall_cnt;
   logic             stalled;
   logic             timeout_hit;

   assign stalled     = ((state == FETCH) || (state == EX1 && opc == 3'b001)) && !mem_ready;
   assign timeout_hit = stalled && (stall_cnt == CNT_W'(TIMEOUT - 1));

   // Counter restarts whenever the state moves or a timeout forces a FETCH retry.
   always_ff @(posedge clk) begin
      if (reset || timeout_hit || (next_state != state)) begin
         stall_cnt <= '0;
      end else if (stalled) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         ir    <= '0;
      end else begin
         state <= next_state;
         if (ir_load) begin
            ir <= ir_in;
         end
      end
   end

   assign state_out = reset ? 3'd0 : state;

   // Every output stays at zero while reset is high, even before the state register clears.
   always_comb begin
      next_state = state;
      ir_load    = 1'b0;
      pc_sel     = 2'b00;
      addr_sel   = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      rf_we      = 1'b0;
      rf_wsel    = '0;
      rf_asel    = '0;
      rf_bsel    = '0;
      md_sel     = 1'b0;
      const_out  = '0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      halted     = 1'b0;
`ifdef WAIT_TIMEOUT_EN
      bus_error  = 1'b0;
`endif
      if (!reset) begin
         case (state)
            FETCH: begin
               mem_rd = 1'b1;
               if (mem_ready) begin
                  ir_load    = 1'b1;
                  pc_sel     = 2'b01;
                  next_state = DECODE;
               end
            end
            DECODE: next_state = EX1;
            EX1: begin
               case (opc)
                  3'b111, 3'b110: begin
                     if (flag) begin
                        pc_sel    = 2'b10;
                        const_out = imm_ext;
                     end
                     instr_done = 1'b1;
                     next_state = FETCH;
                  end
                  3'b001: begin
                     addr_sel = 1'b1;
                     rf_asel  = ra_f;
                     if (mode) begin
                        mem_wr  = 1'b1;
                        rf_bsel = rb_f;
                        if (mem_ready) begin
                           instr_done = 1'b1;
                           next_state = FETCH;
                        end
                     end else begin
                        mem_rd = 1'b1;
                        if (mem_ready) begin
                           next_state = EX2;
                        end
                     end
                  end
                  3'b100: begin
                     rf_we      = 1'b1;
                     rf_wsel    = rd_f;
                     const_out  = imm_ext;
                     instr_done = 1'b1;
                     next_state = FETCH;
                  end
                  3'b000: begin
                     instr_done = 1'b1;
                     next_state = FETCH;
                  end
                  3'b010:  next_state = HALT;
                  default: begin
                     illegal    = 1'b1;
                     next_state = FETCH;
                  end
               endcase
            end
            EX2: begin
               rf_we      = 1'b1;
               rf_wsel    = rd_f;
               md_sel     = 1'b1;
               instr_done = 1'b1;
               next_state = FETCH;
            end
            HALT:    halted = 1'b1;
            default: next_state = FETCH;
         endcase
`ifdef WAIT_TIMEOUT_EN
         if (timeout_hit) begin
            bus_error  = 1'b1;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            next_state = FETCH;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed cases from the test plan plus a
// randomized instruction stream checked against a per-instruction cycle model.
module tb_ctrl_sequencer;

   typedef struct packed {
      logic       ir_load;
      logic [1:0] pc_sel;
      logic       addr_sel;
      logic       mem_rd;
      logic       mem_wr;
      logic       rf_we;
      logic [2:0] rf_wsel;
      logic [2:0] rf_asel;
      logic [2:0] rf_bsel;
      logic       md_sel;
      logic [15:0] const_out;
      logic [2:0] state_out;
      logic       instr_done;
      logic       illegal;
      logic       halted;
   } outs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ir_in;
   logic [3:0]  status;
   logic        mem_ready;
   logic        ir_load, addr_sel, mem_rd, mem_wr, rf_we, md_sel;
   logic        instr_done, illegal, halted;
   logic [1:0]  pc_sel;
   logic [2:0]  rf_wsel, rf_asel, rf_bsel, state_out;
   logic [15:0] const_out;
   outs_t       act;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ctrl_sequencer dut (
      .clk(clk), .reset(reset), .ir_in(ir_in), .status(status), .mem_ready(mem_ready),
      .ir_load(ir_load), .pc_sel(pc_sel), .addr_sel(addr_sel), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_asel(rf_asel),
      .rf_bsel(rf_bsel), .md_sel(md_sel), .const_out(const_out), .state_out(state_out),
      .instr_done(instr_done), .illegal(illegal), .halted(halted)
   );

   assign act = {ir_load, pc_sel, addr_sel, mem_rd, mem_wr, rf_we, rf_wsel, rf_asel,
                 rf_bsel, md_sel, const_out, state_out, instr_done, illegal, halted};

   function automatic outs_t idle(input logic [2:0] st);
      outs_t o;
      o = '0;
      o.state_out = st;
      return o;
   endfunction

   task automatic applyStimulus(input logic r, input logic [15:0] i, input logic [3:0] s,
                                input logic m);
      reset     = r;
      ir_in     = i;
      status    = s;
      mem_ready = m;
   endtask

   // Compare on the falling edge, then advance to just after the next rising edge.
   task automatic checkOutput(input string tag, input outs_t exp);
      @(negedge clk);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, act, exp);
      end
      @(posedge clk);
      #1;
   endtask

   // Expected cycle sequence of one instruction, starting from FETCH.
   task automatic runInstr(input logic [15:0] instr, input int fstall, input int mstall,
                           input logic [3:0] st);
      outs_t e;
      logic [2:0]  opc;
      logic [15:0] imm;
      logic        taken;
      opc = instr[13:11];
      imm = {8'h00, instr[7:0]};
      for (int k = 0; k < fstall; k++) begin
         applyStimulus(1'b0, 16'($urandom), st, 1'b0);
         e = idle(3'd0); e.mem_rd = 1'b1;
         checkOutput("fetch_wait", e);
      end
      applyStimulus(1'b0, instr, st, 1'b1);
      e = idle(3'd0); e.mem_rd = 1'b1; e.ir_load = 1'b1; e.pc_sel = 2'b01;
      checkOutput("fetch", e);
      applyStimulus(1'b0, 16'($urandom), st, 1'($urandom));
      checkOutput("decode", idle(3'd1));
      e = idle(3'd2);
      case (opc)
         3'd7, 3'd6: begin
            taken = (opc == 3'd7) ? st[1] : st[0];
            e.instr_done = 1'b1;
            if (taken) begin
               e.pc_sel = 2'b10;
               e.const_out = imm;
            end
            applyStimulus(1'b0, 16'($urandom), st, 1'($urandom));
            checkOutput("branch", e);
         end
         3'd1: begin
            e.addr_sel = 1'b1;
            e.rf_asel  = instr[5:3];
            if (instr[9]) begin
               e.mem_wr = 1'b1;
               e.rf_bsel = instr[8:6];
            end else begin
               e.mem_rd = 1'b1;
            end
            for (int k = 0; k < mstall; k++) begin
               applyStimulus(1'b0, 16'($urandom), st, 1'b0);
               checkOutput("mem_wait", e);
            end
            e.instr_done = instr[9];
            applyStimulus(1'b0, 16'($urandom), st, 1'b1);
            checkOutput("mem_done", e);
            if (!instr[9]) begin
               e = idle(3'd3);
               e.rf_we = 1'b1; e.rf_wsel = instr[10:8]; e.md_sel = 1'b1; e.instr_done = 1'b1;
               applyStimulus(1'b0, 16'($urandom), st, 1'($urandom));
               checkOutput("ldr_wb", e);
            end
         end
         3'd4: begin
            e.rf_we = 1'b1; e.rf_wsel = instr[10:8]; e.const_out = imm; e.instr_done = 1'b1;
            applyStimulus(1'b0, 16'($urandom), st, 1'($urandom));
            checkOutput("ldi", e);
         end
         3'd0: begin
            e.instr_done = 1'b1;
            applyStimulus(1'b0, 16'($urandom), st, 1'($urandom));
            checkOutput("nop", e);
         end
         3'd2: begin
            applyStimulus(1'b0, 16'($urandom), st, 1'($urandom));
            checkOutput("halt_ex1", e);
            for (int k = 0; k < 3; k++) begin
               e = idle(3'd4); e.halted = 1'b1;
               applyStimulus(1'b0, 16'($urandom), st, 1'b1);
               checkOutput("halted", e);
            end
         end
         default: begin
            e.illegal = 1'b1;
            applyStimulus(1'b0, 16'($urandom), st, 1'($urandom));
            checkOutput("illegal", e);
         end
      endcase
   endtask

   initial begin
      outs_t e;
      logic [15:0] instr;
      int o;

      applyStimulus(1'b1, 16'h2005, 4'h0, 1'b1);
      for (int k = 0; k < 3; k++) checkOutput("reset", idle(3'd0));

      runInstr(16'h2005, 0, 0, 4'h0);
      runInstr(16'h3F10, 0, 0, 4'b0010);
      runInstr(16'h3F10, 1, 0, 4'b0000);
      runInstr(16'h0818, 0, 4, 4'h0);
      runInstr(16'h1800, 0, 0, 4'hF);

      for (int n = 0; n < 60; n++) begin
         do o = int'($urandom_range(0, 7)); while (o == 2);
         instr = 16'($urandom);
         instr[13:11] = 3'(o);
         runInstr(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 4'($urandom));
      end

      // Reset in the middle of a STR stall must drop mem_wr immediately.
      applyStimulus(1'b0, 16'h0A98, 4'h0, 1'b1);
      e = idle(3'd0); e.mem_rd = 1'b1; e.ir_load = 1'b1; e.pc_sel = 2'b01;
      checkOutput("str_fetch", e);
      applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
      checkOutput("str_decode", idle(3'd1));
      e = idle(3'd2); e.mem_wr = 1'b1; e.addr_sel = 1'b1; e.rf_asel = 3'd3; e.rf_bsel = 3'd2;
      checkOutput("str_wait", e);
      applyStimulus(1'b1, 16'h0000, 4'h0, 1'b1);
      checkOutput("str_reset", idle(3'd0));
      applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
      e = idle(3'd0); e.mem_rd = 1'b1;
      checkOutput("after_str_reset", e);

      runInstr(16'h1000, 0, 0, 4'h0);
      applyStimulus(1'b1, 16'h0000, 4'h0, 1'b1);
      checkOutput("halt_reset", idle(3'd0));
      applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
      e = idle(3'd0); e.mem_rd = 1'b1;
      checkOutput("after_halt_reset", e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
